// File: rtl/l2_rd_sched.sv
// Per-channel L2 read scheduler: round-robin over stream requests, per-stream
// line pointers, credit-limited URAM read issue with a registered address slot.
module l2_rd_sched #(
   parameter int unsigned nstrms          = 64,
   parameter int unsigned channels        = 4,
   parameter int unsigned channels_width  = $clog2(channels),
   parameter int unsigned l2_nstrms       = 16,
   parameter int unsigned l2_nstrms_width = $clog2(l2_nstrms),
   parameter int unsigned l2_ncl          = 256,
   parameter int unsigned l2_ncl_width    = $clog2(l2_ncl),
   parameter int unsigned max_out         = 4,
   parameter int unsigned cred_width      = $clog2(max_out + 1)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [nstrms-1:0]                    i_rst_v,
   input  logic [nstrms-1:0]                    i_req_v,
   output logic [nstrms-1:0]                    i_req_r,
   output logic [channels-1:0]                  o_addr_v,
   input  logic [channels-1:0]                  o_addr_r,
   output logic [channels*l2_nstrms_width-1:0]  o_addr_sid,
   output logic [channels*l2_ncl_width-1:0]     o_addr_ptr,
   input  logic [channels-1:0]                  i_cmp_v,
   output logic [channels*cred_width-1:0]       o_cred,
   output logic [channels-1:0]                  o_err
);

   if (nstrms != channels * l2_nstrms || channels_width != $clog2(channels)) begin : g_bad_cfg
      $error("l2_rd_sched: inconsistent stream/channel parameters");
   end

   for (genvar ch = 0; ch < channels; ch++) begin : g_ch
      logic [l2_nstrms-1:0]       elig_c;
      logic [l2_nstrms-1:0]       req_r_c;
      logic [l2_nstrms_width-1:0] last_q;
      logic [l2_nstrms_width-1:0] win_c;
      logic                       found_c;
      logic                       slot_free_c;
      logic                       grant_c;
      logic [cred_width-1:0]      cred_q;
      logic                       err_q;
      logic                       v_q;
      logic [l2_nstrms_width-1:0] sid_q;
      logic [l2_ncl_width-1:0]    aptr_q;
      logic [l2_ncl_width-1:0]    ptr_q [l2_nstrms];

      // A stream held in pointer reset cannot be granted that cycle.
      assign elig_c = i_req_v[ch*l2_nstrms +: l2_nstrms] & ~i_rst_v[ch*l2_nstrms +: l2_nstrms];

      // Round-robin search starting just after the last granted stream.
      always_comb begin
         found_c = 1'b0;
         win_c   = '0;
         for (int unsigned k = 1; k <= l2_nstrms; k++) begin
            int unsigned idx;
            idx = (32'(last_q) + k) % l2_nstrms;
            if (!found_c && elig_c[l2_nstrms_width'(idx)]) begin
               found_c = 1'b1;
               win_c   = l2_nstrms_width'(idx);
            end
         end
      end

      assign slot_free_c = !v_q || o_addr_r[ch];
      assign grant_c     = slot_free_c && (cred_q != '0) && found_c;

      always_comb begin
         req_r_c = '0;
         if (grant_c) req_r_c[win_c] = 1'b1;
      end

      assign i_req_r[ch*l2_nstrms +: l2_nstrms] = req_r_c;

      // Address slot, arbitration history, credits and overflow flag.
      always_ff @(posedge clk) begin
         if (reset) begin
            v_q    <= 1'b0;
            sid_q  <= '0;
            aptr_q <= '0;
            last_q <= l2_nstrms_width'(l2_nstrms - 1);
            cred_q <= cred_width'(max_out);
            err_q  <= 1'b0;
         end else begin
            if (grant_c) begin
               v_q    <= 1'b1;
               sid_q  <= win_c;
               aptr_q <= ptr_q[win_c];
               last_q <= win_c;
            end else if (v_q && o_addr_r[ch]) begin
               v_q <= 1'b0;
            end
            if (grant_c && !i_cmp_v[ch]) begin
               cred_q <= cred_q - cred_width'(1);
            end else if (!grant_c && i_cmp_v[ch]) begin
               if (cred_q == cred_width'(max_out)) err_q <= 1'b1;
               else                                cred_q <= cred_q + cred_width'(1);
            end
         end
      end

      // Per-stream line pointers; reset and increment are mutually exclusive.
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int s = 0; s < int'(l2_nstrms); s++) ptr_q[s] <= '0;
         end else begin
            for (int s = 0; s < int'(l2_nstrms); s++) begin
               if (i_rst_v[ch*l2_nstrms + s])
                  ptr_q[s] <= '0;
               else if (grant_c && win_c == l2_nstrms_width'(s))
                  ptr_q[s] <= ptr_q[s] + l2_ncl_width'(1);
            end
         end
      end

      assign o_addr_v[ch]                                   = v_q;
      assign o_addr_sid[ch*l2_nstrms_width +: l2_nstrms_width] = sid_q;
      assign o_addr_ptr[ch*l2_ncl_width +: l2_ncl_width]    = aptr_q;
      assign o_cred[ch*cred_width +: cred_width]            = cred_q;
      assign o_err[ch]                                      = err_q;
   end

endmodule

// File: tb/tb_l2_rd_sched.sv
// Directed bench for l2_rd_sched: arbitration order, pointers, credits,
// backpressure, pointer wrap/reset, overflow and mid-operation reset.
module tb_l2_rd_sched;

   logic        clk;
   logic        reset;
   logic [63:0] rst_v;
   logic [63:0] req_v;
   logic [63:0] req_r;
   logic [3:0]  addr_v;
   logic [3:0]  addr_r;
   logic [15:0] sid;
   logic [31:0] ptr;
   logic [3:0]  cmp;
   logic [11:0] cred;
   logic [3:0]  err;

   int errors = 0;
   int checks = 0;

   l2_rd_sched dut (
      .clk        (clk),
      .reset      (reset),
      .i_rst_v    (rst_v),
      .i_req_v    (req_v),
      .i_req_r    (req_r),
      .o_addr_v   (addr_v),
      .o_addr_r   (addr_r),
      .o_addr_sid (sid),
      .o_addr_ptr (ptr),
      .i_cmp_v    (cmp),
      .o_cred     (cred),
      .o_err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] sid_at(input int ch);
      return sid[ch*4 +: 4];
   endfunction

   function automatic logic [7:0] ptr_at(input int ch);
      return ptr[ch*8 +: 8];
   endfunction

   function automatic logic [2:0] cred_at(input int ch);
      return cred[ch*3 +: 3];
   endfunction

   int rr_sid [3] = '{3, 5, 9};

   initial begin
      reset  = 1'b1;
      rst_v  = '0;
      req_v  = '0;
      addr_r = '0;
      cmp    = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_addr_v", 64'(addr_v), 64'h0);
      check("rst_req_r", req_r, 64'h0);
      check("rst_err", 64'(err), 64'h0);
      check("rst_cred", 64'(cred), 64'h924);
      check("rst_sid", 64'(sid), 64'h0);
      check("rst_ptr", 64'(ptr), 64'h0);

      // single stream
      req_v  = 64'h1;
      addr_r = 4'hF;
      #1;
      check("t1_req_r", req_r, 64'h1);
      tick();
      req_v = '0;
      cmp   = 4'h1;
      #1;
      check("t1_addr_v", 64'(addr_v[0]), 64'h1);
      check("t1_sid", 64'(sid_at(0)), 64'h0);
      check("t1_ptr", 64'(ptr_at(0)), 64'h0);
      check("t1_cred", 64'(cred_at(0)), 64'h3);
      tick();
      cmp = '0;
      #1;
      check("t1_drop_v", 64'(addr_v), 64'h0);
      check("t1_cred_ret", 64'(cred_at(0)), 64'h4);

      // round-robin among streams 3, 5, 9
      req_v = 64'h228;
      cmp   = 4'h1;
      for (int i = 0; i < 9; i++) begin
         #1;
         check("rr_req_r", req_r, 64'h1 << rr_sid[i % 3]);
         tick();
         check("rr_sid", 64'(sid_at(0)), 64'(rr_sid[i % 3]));
         check("rr_ptr", 64'(ptr_at(0)), 64'(i / 3));
      end
      req_v = '0;
      cmp   = '0;
      tick();
      #1;
      check("rr_drop_v", 64'(addr_v[0]), 64'h0);
      check("rr_cred", 64'(cred_at(0)), 64'h4);

      // credit stall on stream 17 (channel 1)
      req_v = 64'h1 << 17;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("cs_req_r", 64'(req_r[17]), 64'h1);
         tick();
         check("cs_ptr", 64'(ptr_at(1)), 64'(k));
         check("cs_sid", 64'(sid_at(1)), 64'h1);
         check("cs_cred", 64'(cred_at(1)), 64'(3 - k));
      end
      #1;
      check("cs_stall_req_r", 64'(req_r[17]), 64'h0);
      tick();
      check("cs_stall_v", 64'(addr_v[1]), 64'h0);
      cmp = 4'h2;
      #1;
      check("cs_cmp_cycle_req_r", 64'(req_r[17]), 64'h0);
      tick();
      cmp = '0;
      #1;
      check("cs_cred1", 64'(cred_at(1)), 64'h1);
      check("cs_regrant_req_r", 64'(req_r[17]), 64'h1);
      tick();
      check("cs_regrant_ptr", 64'(ptr_at(1)), 64'h4);
      check("cs_regrant_v", 64'(addr_v[1]), 64'h1);
      check("cs_cred0", 64'(cred_at(1)), 64'h0);
      #1;
      check("cs_stall2_req_r", 64'(req_r[17]), 64'h0);
      req_v = '0;
      cmp   = 4'h2;
      repeat (4) tick();
      cmp = '0;
      #1;
      check("cs_cred_full", 64'(cred_at(1)), 64'h4);
      check("cs_no_err", 64'(err), 64'h0);

      // backpressure on channel 2 while channel 3 keeps issuing
      addr_r = 4'b1011;
      req_v  = (64'h1 << 32) | (64'h1 << 33) | (64'h1 << 48);
      cmp    = 4'h8;
      #1;
      check("bp_req_r_ch2", 64'(req_r[33:32]), 64'h1);
      check("bp_req_r_ch3", 64'(req_r[48]), 64'h1);
      tick();
      check("bp_v2", 64'(addr_v[2]), 64'h1);
      check("bp_sid2", 64'(sid_at(2)), 64'h0);
      check("bp_ptr3", 64'(ptr_at(3)), 64'h0);
      for (int i = 1; i < 4; i++) begin
         #1;
         check("bp_hold_req_r_ch2", 64'(req_r[33:32]), 64'h0);
         check("bp_hold_req_r_ch3", 64'(req_r[48]), 64'h1);
         tick();
         check("bp_hold_v2", 64'(addr_v[2]), 64'h1);
         check("bp_hold_sid2", 64'(sid_at(2)), 64'h0);
         check("bp_hold_ptr2", 64'(ptr_at(2)), 64'h0);
         check("bp_ptr3", 64'(ptr_at(3)), 64'(i));
      end
      addr_r = 4'hF;
      #1;
      check("bp_release_req_r", 64'(req_r[33:32]), 64'h2);
      tick();
      check("bp_release_sid2", 64'(sid_at(2)), 64'h1);
      check("bp_release_ptr2", 64'(ptr_at(2)), 64'h0);
      req_v = '0;
      cmp   = 4'h4;
      repeat (2) tick();
      cmp = '0;
      #1;
      check("bp_cred2", 64'(cred_at(2)), 64'h4);
      check("bp_cred3", 64'(cred_at(3)), 64'h4);
      check("bp_no_err", 64'(err), 64'h0);

      // pointer reset then full wrap on stream 0
      req_v = 64'h1;
      rst_v = 64'h1;
      #1;
      check("pr_req_r", 64'(req_r[0]), 64'h0);
      tick();
      rst_v = '0;
      cmp   = 4'h1;
      for (int k = 0; k < 257; k++) begin
         #1;
         check("wr_req_r", 64'(req_r[0]), 64'h1);
         tick();
         check("wr_ptr", 64'(ptr_at(0)), 64'(k % 256));
      end
      cmp   = '0;
      rst_v = 64'h1;
      #1;
      check("pr2_req_r", 64'(req_r[0]), 64'h0);
      tick();
      rst_v = '0;
      #1;
      check("pr2_regrant_req_r", 64'(req_r[0]), 64'h1);
      tick();
      check("pr2_ptr", 64'(ptr_at(0)), 64'h0);
      req_v = '0;
      cmp   = 4'h1;
      tick();
      cmp = '0;
      #1;
      check("pr2_cred", 64'(cred_at(0)), 64'h4);

      // credit overflow, then reset with a pending address
      cmp = 4'h8;
      tick();
      cmp = '0;
      #1;
      check("ov_err", 64'(err), 64'h8);
      check("ov_cred3", 64'(cred_at(3)), 64'h4);
      req_v = 64'h1;
      tick();
      req_v = '0;
      #1;
      check("rm_pending_v", 64'(addr_v[0]), 64'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rm_addr_v", 64'(addr_v), 64'h0);
      check("rm_err", 64'(err), 64'h0);
      check("rm_cred", 64'(cred), 64'h924);
      check("rm_sid", 64'(sid), 64'h0);
      check("rm_ptr", 64'(ptr), 64'h0);
      check("rm_req_r", req_r, 64'h0);
      req_v = 64'h1;
      #1;
      check("rm_first_req_r", req_r, 64'h1);
      tick();
      req_v = '0;
      check("rm_first_ptr", 64'(ptr_at(0)), 64'h0);
      check("rm_first_v", 64'(addr_v[0]), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
